// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the two-master I2C bus arbiter.
package i2c_arb_pkg;

    typedef enum logic [1:0] {IDLE_WAIT, FREE, GRANT, RECOVER} arb_state_e;

    typedef enum logic [1:0] {PULSE, STOP_LO, STOP_HI} rec_phase_e;

    localparam int unsigned RECOVERY_PULSES = 9;
    // Half-period index of the high phase of the final recovery pulse.
    localparam int unsigned LAST_HALF = 2 * RECOVERY_PULSES - 1;

    // Round-robin pick: on a tie the master not granted last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Bus-level observer: synchronizes SCL/SDA and tracks idle time, stuck SDA and STOP conditions.
module i2c_bus_monitor
    import i2c_arb_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES  = 140,
    parameter int unsigned STUCK_CYCLES = 2800000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_s,
    output logic sda_s,
    output logic bus_idle,
    output logic sda_stuck,
    output logic stop_seen
);

    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);

    logic [1:0]    scl_sync_q;
    logic [1:0]    sda_sync_q;
    logic          sda_prev_q;
    logic [IW-1:0] idle_q, idle_d;
    logic [SW-1:0] stuck_q, stuck_d;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign stop_seen = scl_s & sda_s & ~sda_prev_q;

    always_comb begin
        idle_d  = '0;
        stuck_d = '0;
        if (!clr) begin
            if (scl_s && sda_s) begin
                idle_d = (idle_q == IW'(IDLE_CYCLES)) ? idle_q : idle_q + 1'b1;
            end
            if (!sda_s) begin
                stuck_d = (stuck_q == SW'(STUCK_CYCLES)) ? stuck_q : stuck_q + 1'b1;
            end
        end
    end

    // Flags look at the next count so the FSM moves on the edge the count is reached.
    assign bus_idle  = (idle_d == IW'(IDLE_CYCLES));
    assign sda_stuck = (stuck_d == SW'(STUCK_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b00;
            sda_sync_q <= 2'b00;
            sda_prev_q <= 1'b0;
            idle_q     <= '0;
            stuck_q    <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            sda_prev_q <= sda_s;
            idle_q     <= idle_d;
            stuck_q    <= stuck_d;
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Two-master I2C bus arbiter: round-robin grant, drive gating and stuck-SDA recovery.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES  = 140,
    parameter int unsigned STUCK_CYCLES = 2800000,
    parameter int unsigned HALF_CYCLES  = 140
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       m0_scl_t,
    input  logic       m0_sda_t,
    input  logic       m1_scl_t,
    input  logic       m1_sda_t,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_t,
    output logic       sda_t,
    output logic       busy,
    output logic       bus_error
);

    localparam int unsigned HW = $clog2(HALF_CYCLES + 1);

    arb_state_e    state_q, state_d;
    rec_phase_e    phase_q, phase_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic [4:0]    half_idx_q, half_idx_d;
    logic          bus_error_d;
    logic          half_end;

    logic scl_s, sda_s, bus_idle, sda_stuck, stop_seen;
    logic own_scl, own_sda, rec_scl, rec_sda;

    i2c_bus_monitor #(
        .IDLE_CYCLES  (IDLE_CYCLES),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_monitor (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q != IDLE_WAIT),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .bus_idle  (bus_idle),
        .sda_stuck (sda_stuck),
        .stop_seen (stop_seen)
    );

    assign half_end = (half_cnt_q == HW'(HALF_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        owner_d     = owner_q;
        last_d      = last_q;
        half_cnt_d  = half_cnt_q;
        half_idx_d  = half_idx_q;
        bus_error_d = 1'b0;
        case (state_q)
            IDLE_WAIT: begin
                if (sda_stuck) begin
                    state_d     = RECOVER;
                    phase_d     = PULSE;
                    half_cnt_d  = '0;
                    half_idx_d  = '0;
                    bus_error_d = 1'b1;
                end else if (bus_idle) begin
                    state_d = FREE;
                end
            end
            FREE: begin
                if (req != 2'b00) begin
                    state_d = GRANT;
                    owner_d = rr_pick(req, last_q);
                    last_d  = owner_d;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = IDLE_WAIT;
                end
            end
            RECOVER: begin
                half_cnt_d = half_end ? '0 : half_cnt_q + 1'b1;
                if (half_end) begin
                    unique case (phase_q)
                        PULSE: begin
                            // Decide at the end of each SCL-high half: done, or slave let go of SDA.
                            if (half_idx_q[0] && (half_idx_q == 5'(LAST_HALF) || sda_s)) begin
                                phase_d = STOP_LO;
                            end else begin
                                half_idx_d = half_idx_q + 5'd1;
                            end
                        end
                        STOP_LO: phase_d = STOP_HI;
                        STOP_HI: state_d = IDLE_WAIT;
                        default: state_d = IDLE_WAIT;
                    endcase
                end
            end
            default: state_d = IDLE_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE_WAIT;
            phase_q    <= PULSE;
            owner_q    <= 1'b0;
            last_q     <= 1'b0;
            half_cnt_q <= '0;
            half_idx_q <= '0;
            bus_error  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            half_cnt_q <= half_cnt_d;
            half_idx_q <= half_idx_d;
            bus_error  <= bus_error_d;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (state_q == GRANT) begin
            gnt = owner_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        own_scl = 1'b1;
        own_sda = 1'b1;
        if (gnt[1]) begin
            own_scl = m1_scl_t;
            own_sda = m1_sda_t;
        end else if (gnt[0]) begin
            own_scl = m0_scl_t;
            own_sda = m0_sda_t;
        end
    end

    always_comb begin
        rec_scl = 1'b1;
        rec_sda = 1'b1;
        if (state_q == RECOVER) begin
            rec_sda = (phase_q == PULSE);
            rec_scl = (phase_q == PULSE) ? half_idx_q[0] : (phase_q == STOP_HI);
        end
    end

    assign scl_t = own_scl & rec_scl;
    assign sda_t = own_sda & rec_sda;
    assign busy  = (state_q != FREE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench: stimulus queues timestamped output events, a negedge monitor checks them.
module tb_i2c_bus_arbiter;

    localparam int unsigned IDLE  = 140;
    localparam int unsigned STUCK = 500;
    localparam int unsigned HALF  = 140;

    localparam int R  = 3;             // last edge with rst asserted
    localparam int T  = R + 600 + 2 + STUCK;
    localparam int T2 = R + 4060 + 2 + STUCK;
    localparam int F  = R + 5900;
    localparam int R2 = F + 11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       m0_scl_t, m0_sda_t, m1_scl_t, m1_sda_t;
    logic       ext_scl, ext_sda;
    logic       scl_i, sda_i, scl_t, sda_t, busy, bus_error;

    // Open-drain bus: any driver pulling low wins.
    assign scl_i = scl_t & ext_scl;
    assign sda_i = sda_t & ext_sda;

    i2c_bus_arbiter #(
        .IDLE_CYCLES  (IDLE),
        .STUCK_CYCLES (STUCK),
        .HALF_CYCLES  (HALF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .m0_scl_t  (m0_scl_t),
        .m0_sda_t  (m0_sda_t),
        .m1_scl_t  (m1_scl_t),
        .m1_sda_t  (m1_sda_t),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_t     (scl_t),
        .sda_t     (sda_t),
        .busy      (busy),
        .bus_error (bus_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         t;
        logic [4:0] v;
    } ev_t;

    ev_t        exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b0;
    logic [4:0] prev_obs;
    logic [4:0] obs;

    assign obs = {gnt, bus_error, scl_t, sda_t};

    function automatic logic [4:0] mk(input logic [1:0] g, input logic be, input logic sc,
                                      input logic sd);
        return {g, be, sc, sd};
    endfunction

    task automatic push(input int t, input logic [4:0] v);
        exp_q.push_back('{t: t, v: v});
    endtask

    task automatic goto(input int c);
        repeat (c - cyc) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, want);
        end
    endtask

    // Every change of {gnt, bus_error, scl_t, sda_t} must match the next queued event.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (mon_en && obs !== prev_obs) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d got=%b required=no_change", cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.v !== obs) begin
                    failures++;
                    $display("FAIL event got cyc=%0d obs=%b required cyc=%0d obs=%b",
                             cyc, obs, e.t, e.v);
                end
            end
            prev_obs = obs;
        end
    end

    initial begin
        rst = 1'b1;
        req = 2'b00;
        m0_scl_t = 1'b1; m0_sda_t = 1'b1; m1_scl_t = 1'b1; m1_sda_t = 1'b1;
        ext_scl = 1'b1;  ext_sda = 1'b1;

        goto(R);
        check("reset_gnt", 8'(gnt), 8'h0);
        check("reset_scl_t", 8'(scl_t), 8'h1);
        check("reset_sda_t", 8'(sda_t), 8'h1);
        check("reset_busy", 8'(busy), 8'h1);
        check("reset_bus_error", 8'(bus_error), 8'h0);

        // Tie after reset goes to master 1, then round-robin hands master 0 the next tie.
        rst = 1'b0;
        req = 2'b11;
        prev_obs = obs;
        mon_en = 1'b1;
        push(R + 143, mk(2'b10, 0, 1, 1));
        push(R + 152, mk(2'b10, 0, 1, 0));
        push(R + 154, mk(2'b10, 0, 1, 1));
        push(R + 161, mk(2'b00, 0, 1, 1));
        push(R + 302, mk(2'b01, 0, 1, 1));
        push(R + 310, mk(2'b01, 0, 0, 1));
        push(R + 311, mk(2'b01, 0, 0, 0));
        push(R + 321, mk(2'b00, 0, 1, 1));
        push(R + 569, mk(2'b10, 0, 1, 1));
        push(R + 581, mk(2'b00, 0, 1, 1));

        goto(R + 150); m0_sda_t = 1'b0;
        #1 check("nonowner_gated_sda", 8'(sda_t), 8'h1);
        check("grant_busy", 8'(busy), 8'h1);
        goto(R + 152); m1_sda_t = 1'b0;
        goto(R + 154); m1_sda_t = 1'b1;
        goto(R + 155); m0_sda_t = 1'b1;
        goto(R + 160); req = 2'b01;
        goto(R + 170); req = 2'b11;
        // Master 0 owns the bus, starts a byte, then drops req with both lines low.
        goto(R + 310); m0_scl_t = 1'b0;
        goto(R + 311); m0_sda_t = 1'b0;
        goto(R + 320); req = 2'b10;
        goto(R + 330); m0_scl_t = 1'b1; m0_sda_t = 1'b1;
        // SCL glitch at idle count 100 restarts the idle window.
        goto(R + 423); ext_scl = 1'b0;
        goto(R + 426); ext_scl = 1'b1;
        goto(R + 580); req = 2'b00;

        // Stuck SDA: full 9-pulse recovery, request raised mid-recovery is honoured later.
        push(T, mk(2'b00, 1, 0, 1));
        push(T + 1, mk(2'b00, 0, 0, 1));
        for (int k = 1; k <= 17; k++) begin
            push(T + k * HALF, mk(2'b00, 0, k[0], 1));
        end
        push(T + 18 * HALF, mk(2'b00, 0, 0, 0));
        push(T + 19 * HALF, mk(2'b00, 0, 1, 0));
        push(T + 20 * HALF, mk(2'b00, 0, 1, 1));
        push(T + 20 * HALF + 143, mk(2'b01, 0, 1, 1));
        push(R + 4051, mk(2'b00, 0, 1, 1));

        goto(R + 600); ext_sda = 1'b0;
        goto(T + 100); req = 2'b01;
        goto(T + 18 * HALF + 5); ext_sda = 1'b1;
        goto(R + 4050); req = 2'b00;

        // Stuck SDA released during pulse 3: STOP follows pulse 3.
        push(T2, mk(2'b00, 1, 0, 1));
        push(T2 + 1, mk(2'b00, 0, 0, 1));
        for (int k = 1; k <= 5; k++) begin
            push(T2 + k * HALF, mk(2'b00, 0, k[0], 1));
        end
        push(T2 + 6 * HALF, mk(2'b00, 0, 0, 0));
        push(T2 + 7 * HALF, mk(2'b00, 0, 1, 0));
        push(T2 + 8 * HALF, mk(2'b00, 0, 1, 1));

        goto(R + 4060); ext_sda = 1'b0;
        goto(T2 + 4 * HALF + 10); ext_sda = 1'b1;
        goto(R + 5880);
        check("free_busy", 8'(busy), 8'h0);

        // Reset while master 0 owns the bus and holds SDA low.
        push(F + 1, mk(2'b01, 0, 1, 1));
        push(F + 5, mk(2'b01, 0, 1, 0));
        push(F + 11, mk(2'b00, 0, 1, 1));
        push(R2 + 143, mk(2'b10, 0, 1, 1));
        push(R2 + 151, mk(2'b00, 0, 1, 1));

        goto(F); req = 2'b01;
        goto(F + 5); m0_sda_t = 1'b0;
        goto(F + 10); req = 2'b11; rst = 1'b1;
        goto(F + 11);
        check("midrst_gnt", 8'(gnt), 8'h0);
        check("midrst_sda_t", 8'(sda_t), 8'h1);
        check("midrst_busy", 8'(busy), 8'h1);
        rst = 1'b0;
        m0_sda_t = 1'b1;
        goto(R2 + 150); req = 2'b00;
        goto(R2 + 160);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events got=%0d pending required=0 next_cyc=%0d",
                     exp_q.size(), exp_q[0].t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
